// File: rtl/uart_pkg.sv
// Shared definitions for the uart transmit-side queue: word width default,
// issue-FSM state encoding and the WAIT_BUSY timeout.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS       = 8;
    localparam int unsigned TXQ_WAIT_BUSY_CYCLES = 2;
    localparam int unsigned TXQ_WAIT_W           = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } txq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: storage, wrapping pointers, level counter and
// registered empty/full flags. Push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned DEPTH     = 16,
    localparam int unsigned PTR_W    = $clog2(DEPTH),
    localparam int unsigned LVL_W    = $clog2(DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] rdata,
    output logic [LVL_W-1:0]     level,
    output logic                 empty,
    output logic                 full
);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 empty_q, empty_d;
    logic                 full_q, full_d;
    logic                 do_push, do_pop;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        do_push  = push && !full_q;
        do_pop   = pop && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
        empty_d = (level_d == '0);
        full_d  = (level_d == LVL_W'(DEPTH));
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign level = level_q;
    assign empty = empty_q;
    assign full  = full_q;

endmodule

// File: rtl/uart_tx_queue.sv
// Transmit byte queue feeding the uart tx_data/tx_send interface, paced on tx_busy.
// Optional sticky overflow flag and ovf_clr port when UART_TXQ_OVERFLOW_EN is defined.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = UART_DATA_BITS,
    parameter int unsigned DEPTH     = 16,
    localparam int unsigned LVL_W    = $clog2(DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_send,
    input  logic                 tx_busy,
    output logic [LVL_W-1:0]     level,
    output logic                 empty,
    output logic                 full
`ifdef UART_TXQ_OVERFLOW_EN
    ,
    output logic                 overflow,
    input  logic                 ovf_clr
`endif
);

    txq_state_t             state_q, state_d;
    logic [DATA_BITS-1:0]   tx_data_q, tx_data_d;
    logic                   tx_send_q, tx_send_d;
    logic [TXQ_WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic                   pop;
    logic [DATA_BITS-1:0]   fifo_rdata;

    assign in_ready = !full;

    sync_fifo #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clock (clock),
        .rst_n (rst_n),
        .push  (in_valid && in_ready),
        .wdata (in_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .level (level),
        .empty (empty),
        .full  (full)
    );

    // Issue FSM: pop only from IDLE; a missing busy response times out so a lost frame cannot hang the queue.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_send_d  = 1'b0;
        wait_cnt_d = wait_cnt_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    pop        = 1'b1;
                    tx_data_d  = fifo_rdata;
                    tx_send_d  = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (wait_cnt_q == TXQ_WAIT_W'(TXQ_WAIT_BUSY_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + TXQ_WAIT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            tx_send_q  <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_send_q  <= tx_send_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign tx_data = tx_data_q;
    assign tx_send = tx_send_q;

`ifdef UART_TXQ_OVERFLOW_EN
    logic overflow_q, overflow_d;

    // Sticky; a new overflow in the clearing cycle wins over the clear.
    always_comb begin
        overflow_d = overflow_q;
        if (ovf_clr)           overflow_d = 1'b0;
        if (in_valid && full)  overflow_d = 1'b1;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) overflow_q <= 1'b0;
        else        overflow_q <= overflow_d;
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: queue-based reference model, uart busy model,
// table-driven single-word latency vectors, hand-written corner sequences, random phase.
module tb_uart_tx_queue;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LW    = 5;
    localparam int          FRAME = 24;

    logic          clock = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] tx_data;
    logic          tx_send;
    logic          tx_busy;
    logic [LW-1:0] level;
    logic          empty;
    logic          full;
`ifdef UART_TXQ_OVERFLOW_EN
    logic          overflow;
    logic          ovf_clr;
`endif

    int checks   = 0;
    int failures = 0;

    uart_tx_queue #(.DATA_BITS(DW), .DEPTH(DEPTH)) dut (
`ifdef UART_TXQ_OVERFLOW_EN
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
`endif
        .clock    (clock),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx_data  (tx_data),
        .tx_send  (tx_send),
        .tx_busy  (tx_busy),
        .level    (level),
        .empty    (empty),
        .full     (full)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // uart model: goes busy for FRAME cycles after each tx_send unless silent
    logic        ext_busy;
    logic        silent;
    int          busy_cnt = 0;
    logic [7:0]  rx_q[$];

    always @(posedge clock) begin
        if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        if (tx_send) begin
            rx_q.push_back(tx_data);
            if (!silent) busy_cnt <= FRAME;
        end
    end
    assign tx_busy = (busy_cnt != 0) || ext_busy;

    // Reference model: FIFO order of accepted words, level = accepted - issued
    logic [7:0] exp_q[$];
    int         acc, sends, cyc, last_send_cyc, last_gap;
    logic [7:0] last_sent;
    logic       have_sent;
    logic       gap_chk, lvl_hold;

    always @(negedge clock) begin
        if (!rst_n) begin
            exp_q.delete();
            acc = 0; sends = 0; have_sent = 1'b0; last_sent = '0; last_send_cyc = -1;
        end else begin
            cyc++;
            if (tx_send) begin
                chk("send has queued word", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    chk("tx_data order", 32'(tx_data), 32'(exp_q[0]));
                    last_sent = exp_q.pop_front();
                end
                sends++;
                have_sent = 1'b1;
                if (last_send_cyc >= 0) begin
                    last_gap = cyc - last_send_cyc;
                    if (gap_chk) chk("frame gap", 32'(last_gap >= FRAME + 2), 1);
                end
                last_send_cyc = cyc;
            end else begin
                chk("tx_data hold", 32'(tx_data), have_sent ? 32'(last_sent) : 0);
            end
            chk("level", 32'(level), 32'(acc - sends));
            chk("empty", 32'(empty), 32'(acc == sends));
            chk("full", 32'(full), 32'((acc - sends) == DEPTH));
            chk("in_ready", 32'(in_ready), 32'((acc - sends) != DEPTH));
            if (lvl_hold) chk("level steady", 32'(level), 15);
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                acc++;
            end
        end
    end

    task automatic wait_drain(input string nm, input int budget);
        int n = 0;
        while (n < budget && !(level == 0 && exp_q.size() == 0)) begin
            @(negedge clock);
            n++;
        end
        chk(nm, 32'(level == 0 && exp_q.size() == 0), 1);
        repeat (FRAME + 8) @(negedge clock);
    endtask

    typedef struct {
        logic [7:0]  data;
        int          busy_cycles;
        logic [7:0]  exp_data;
        int          exp_lat;
    } vec_t;
    vec_t vecs[4];

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, lat, e;
        vecs[0] = '{8'hA5, 0, 8'hA5, 2};
        vecs[1] = '{8'h3C, 1, 8'h3C, 3};
        vecs[2] = '{8'hFF, 5, 8'hFF, 7};
        vecs[3] = '{8'h00, 3, 8'h00, 5};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        ext_busy = 1'b0; silent = 1'b0; gap_chk = 1'b0; lvl_hold = 1'b0;
        cyc = 0; last_gap = 0;
`ifdef UART_TXQ_OVERFLOW_EN
        ovf_clr = 1'b0;
`endif
        #12;
        chk("reset tx_send", 32'(tx_send), 0);
        chk("reset tx_data", 32'(tx_data), 0);
        chk("reset level", 32'(level), 0);
        chk("reset empty", 32'(empty), 1);
        chk("reset in_ready", 32'(in_ready), 1);
`ifdef UART_TXQ_OVERFLOW_EN
        chk("reset overflow", 32'(overflow), 0);
`endif
        @(negedge clock); #1 rst_n = 1'b1;

        // Single words into an empty queue, with optional external busy hold-off
        for (int v = 0; v < 4; v++) begin
            wait_drain("drain before vector", 400);
            @(posedge clock); #2;
            in_data = vecs[v].data; in_valid = 1'b1; ext_busy = (vecs[v].busy_cycles != 0);
            @(posedge clock); #2;
            in_valid = 1'b0;
            lat = 0; e = 0;
            for (int c = 1; c <= 30 && lat == 0; c++) begin
                @(negedge clock);
                if (tx_send) begin
                    lat = c;
                    chk("vector tx_data", 32'(tx_data), 32'(vecs[v].exp_data));
                end
                @(posedge clock); #2;
                e++;
                if (e == vecs[v].busy_cycles) ext_busy = 1'b0;
            end
            ext_busy = 1'b0;
            chk("vector latency", 32'(lat), 32'(vecs[v].exp_lat));
        end
        wait_drain("drain after vectors", 400);
        chk("level back to 0", 32'(level), 0);

        // Burst of 16 into a held-off queue, stall while full, then paced drain
        base = rx_q.size();
        ext_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clock); #2;
            in_valid = 1'b1; in_data = 8'(i + 1);
        end
        @(posedge clock); #2;
        in_data = 8'hEE;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("burst full", 32'(full), 1);
        chk("burst in_ready", 32'(in_ready), 0);
        chk("burst level", 32'(level), 16);
        @(posedge clock); #2;
        in_valid = 1'b0; ext_busy = 1'b0; gap_chk = 1'b1;
        wait_drain("burst drain", 1500);
        gap_chk = 1'b0;
        chk("burst count", 32'(rx_q.size() - base), 16);
        for (int i = 0; i < 16 && base + i < rx_q.size(); i++)
            chk("burst order", 32'(rx_q[base + i]), 32'(i + 1));

        // Fill to 15, then push exactly on each pop edge with a uart that never goes busy
        silent = 1'b1; ext_busy = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clock); #2;
            in_valid = 1'b1; in_data = 8'(8'h40 + i);
        end
        @(posedge clock); #2;
        in_valid = 1'b0;
        @(negedge clock);
        chk("fill to 15", 32'(level), 15);
        @(posedge clock); #2;
        ext_busy = 1'b0; in_valid = 1'b1; in_data = 8'h80;
        @(posedge clock); #2;
        in_valid = 1'b0; lvl_hold = 1'b1;
        for (int j = 1; j <= 13; j++) begin
            @(posedge clock);
            @(posedge clock); #2;
            in_valid = 1'b1; in_data = 8'(8'h80 + j);
            @(posedge clock); #2;
            in_valid = 1'b0;
        end
        lvl_hold = 1'b0;
        chk("timeout pacing gap", 32'(last_gap), 3);
        wait_drain("wrap drain", 400);
        silent = 1'b0;

`ifdef UART_TXQ_OVERFLOW_EN
        // Overflow set, set-beats-clear, then clear
        ext_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clock); #2;
            in_valid = 1'b1; in_data = 8'(8'hC0 + i);
        end
        @(posedge clock); #2;
        in_data = 8'h99;
        @(negedge clock);
        chk("overflow before set", 32'(overflow), 0);
        @(posedge clock); #2;
        in_valid = 1'b0;
        @(negedge clock);
        chk("overflow set", 32'(overflow), 1);
        chk("overflow level", 32'(level), 16);
        @(posedge clock); #2;
        in_valid = 1'b1; ovf_clr = 1'b1;
        @(posedge clock); #2;
        in_valid = 1'b0;
        @(negedge clock);
        chk("overflow set wins", 32'(overflow), 1);
        @(posedge clock); #2;
        ovf_clr = 1'b0;
        @(negedge clock);
        chk("overflow cleared", 32'(overflow), 0);
        ext_busy = 1'b0;
        wait_drain("overflow drain", 1000);
`endif

        // Random traffic with occasional external busy
        for (int i = 0; i < 400; i++) begin
            @(posedge clock); #2;
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            ext_busy = ($urandom_range(0, 9) == 0);
        end
        @(posedge clock); #2;
        in_valid = 1'b0; ext_busy = 1'b0;
        wait_drain("random drain", 8000);

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #2;
            in_valid = 1'b1; in_data = 8'(8'h11 + i);
        end
        @(posedge clock); #2;
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        chk("pre-reset level nonzero", 32'(level != 0), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid reset tx_send", 32'(tx_send), 0);
        chk("mid reset tx_data", 32'(tx_data), 0);
        chk("mid reset level", 32'(level), 0);
        chk("mid reset empty", 32'(empty), 1);
        chk("mid reset in_ready", 32'(in_ready), 1);
        repeat (2) @(negedge clock);
        #1 rst_n = 1'b1;
        repeat (FRAME + 10) @(negedge clock);
        chk("post reset level", 32'(level), 0);
        chk("post reset empty", 32'(empty), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
